// File: rtl/clause_register.sv
// clause_register: grants one of four unsatisfied-clause buffers, loads a
// three-literal clause, issues three address-table reads (one per literal),
// then picks a literal to flip using a random count.
module clause_register (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_en,
    input  logic [4:0]  count,
    input  logic [35:0] reg_in,
    input  logic [4:1]  ucb_req,
    output logic [4:1]  ucb_gnt,
    output logic [11:0] AT_address,
    output logic        AT_read,
    output logic [2:0]  cnt,
    output logic [11:0] flip_index,
    output logic [1:0]  temp_address
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT  = 3'd1,
        LOAD   = 3'd2,
        READ   = 3'd3,
        SELECT = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [35:0] clause;
    logic [4:1]  gnt_pick;
    logic [1:0]  sel_idx;

    // Literal k of a clause word sits in bits [12k+11:12k].
    function automatic logic [11:0] literal(input logic [35:0] c, input logic [1:0] k);
        case (k)
            2'd0:    literal = c[11:0];
            2'd1:    literal = c[23:12];
            default: literal = c[35:24];
        endcase
    endfunction

    // Fixed-priority pick among requests, buffer 4 highest.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        gnt_pick = '0;
        if (ucb_req[4])      gnt_pick[4] = 1'b1;
        else if (ucb_req[3]) gnt_pick[3] = 1'b1;
        else if (ucb_req[2]) gnt_pick[2] = 1'b1;
        else if (ucb_req[1]) gnt_pick[1] = 1'b1;
    end

    // Literal selected for flipping: count mod 3.
    always_comb begin
        sel_idx = 2'(count % 5'd3);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|ucb_req) state_next = GRANT;
            GRANT:   state_next = LOAD;
            LOAD:    if (reg_en) state_next = READ;
            READ:    if (temp_address == 2'd2) state_next = SELECT;
            SELECT:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs and clause storage, updated according to the current state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the clause register is a plain 36-bit register, not a memory array, so clearing it on reset is cheap and intended.
            clause       <= '0;
            ucb_gnt      <= '0;
            AT_address   <= '0;
            AT_read      <= 1'b0;
            cnt          <= '0;
            flip_index   <= '0;
            temp_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|ucb_req) ucb_gnt <= gnt_pick;
                end
                LOAD: begin
                    if (reg_en) begin
                        clause       <= reg_in;
                        temp_address <= 2'd0;
                        cnt          <= 3'd0;
                        AT_read      <= 1'b1;
                        AT_address   <= reg_in[11:0];
                    end
                end
                READ: begin
                    cnt <= cnt + 3'd1;
                    if (temp_address == 2'd2) begin
                        AT_read <= 1'b0;
                    end else begin
                        temp_address <= temp_address + 2'd1;
                        AT_address   <= literal(clause, temp_address + 2'd1);
                    end
                end
                SELECT: begin
                    flip_index <= literal(clause, sel_idx);
                end
                DONE: begin
                    ucb_gnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clause_register.sv
// Self-checking bench for clause_register: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// transaction-step reference model.
module tb_clause_register;

    logic        clk;
    logic        rst;
    logic        reg_en;
    logic [4:0]  count;
    logic [35:0] reg_in;
    logic [4:1]  ucb_req;
    logic [4:1]  ucb_gnt;
    logic [11:0] AT_address;
    logic        AT_read;
    logic [2:0]  cnt;
    logic [11:0] flip_index;
    logic [1:0]  temp_address;

    int errors = 0;
    int checks = 0;

    clause_register dut (
        .clk          (clk),
        .rst          (rst),
        .reg_en       (reg_en),
        .count        (count),
        .reg_in       (reg_in),
        .ucb_req      (ucb_req),
        .ucb_gnt      (ucb_gnt),
        .AT_address   (AT_address),
        .AT_read      (AT_read),
        .cnt          (cnt),
        .flip_index   (flip_index),
        .temp_address (temp_address)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // step: 0 waiting for requests, 1 just granted, 2 waiting for clause,
    // 3..5 issuing read of literal (step-3), 6 selecting, 7 releasing grant.
    int          m_step = 0;
    logic [35:0] m_clause = '0;
    logic [4:1]  m_gnt = '0;
    logic [11:0] m_addr = '0;
    logic        m_read = 1'b0;
    logic [2:0]  m_cnt = '0;
    logic [11:0] m_flip = '0;
    logic [1:0]  m_ta = '0;
    bit          m_valid = 1'b0;

    function automatic logic [11:0] lit_of(input logic [35:0] c, input int k);
        return 12'((c >> (12 * k)) & 36'hFFF);
    endfunction

    function automatic logic [4:1] top_req(input logic [4:1] r);
        logic [4:1] g;
        g = '0;
        for (int i = 4; i >= 1; i--) begin
            if (r[i]) begin
                g[i] = 1'b1;
                break;
            end
        end
        return g;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_valid  <= 1'b1;
            m_step   <= 0;
            m_clause <= '0;
            m_gnt    <= '0;
            m_addr   <= '0;
            m_read   <= 1'b0;
            m_cnt    <= '0;
            m_flip   <= '0;
            m_ta     <= '0;
        end else begin
            case (m_step)
                0: if (ucb_req != 0) begin
                    m_gnt  <= top_req(ucb_req);
                    m_step <= 1;
                end
                1: m_step <= 2;
                2: if (reg_en) begin
                    m_clause <= reg_in;
                    m_ta     <= 2'd0;
                    m_cnt    <= 3'd0;
                    m_read   <= 1'b1;
                    m_addr   <= lit_of(reg_in, 0);
                    m_step   <= 3;
                end
                3, 4: begin
                    m_ta   <= 2'(m_step - 2);
                    m_cnt  <= 3'(m_step - 2);
                    m_addr <= lit_of(m_clause, m_step - 2);
                    m_step <= m_step + 1;
                end
                5: begin
                    m_cnt  <= 3'd3;
                    m_read <= 1'b0;
                    m_step <= 6;
                end
                6: begin
                    m_flip <= lit_of(m_clause, int'(count) % 3);
                    m_step <= 7;
                end
                default: begin
                    m_gnt  <= '0;
                    m_step <= 0;
                end
            endcase
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("gnt",   36'(ucb_gnt),      36'(m_gnt));
            check("addr",  36'(AT_address),   36'(m_addr));
            check("read",  36'(AT_read),      36'(m_read));
            check("cnt",   36'(cnt),          36'(m_cnt));
            check("flip",  36'(flip_index),   36'(m_flip));
            check("taddr", 36'(temp_address), 36'(m_ta));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Entered at the negedge where the grant is first visible (GRANT state);
    // returns at the negedge of the following IDLE cycle.
    task automatic run_clause(input logic [35:0] c, input logic [4:0] cval, input logic [11:0] exp_flip);
        tick();                 // LOAD
        reg_en = 1'b1;
        reg_in = c;
        count  = cval;
        tick();                 // READ 0
        reg_en = 1'b0;
        check("lit_read0", 36'(AT_read), 36'd1);
        check("lit_addr0", 36'(AT_address), 36'(lit_of(c, 0)));
        tick();                 // READ 1
        check("lit_addr1", 36'(AT_address), 36'(lit_of(c, 1)));
        tick();                 // READ 2
        check("lit_addr2", 36'(AT_address), 36'(lit_of(c, 2)));
        check("lit_ta2", 36'(temp_address), 36'd2);
        tick();                 // SELECT
        check("lit_cnt3", 36'(cnt), 36'd3);
        check("lit_read_off", 36'(AT_read), 36'd0);
        tick();                 // DONE
        check("lit_flip", 36'(flip_index), 36'(exp_flip));
        tick();                 // IDLE
        check("lit_gnt_clr", 36'(ucb_gnt), 36'd0);
    endtask

    localparam logic [35:0] CL123 = {12'h003, 12'h002, 12'h001};

    initial begin
        rst     = 1'b0;
        reg_en  = 1'b0;
        count   = '0;
        reg_in  = '0;
        ucb_req = 4'b1111;

        // Reset held two cycles with every request asserted.
        tick();
        check("rst_gnt0", 36'(ucb_gnt), 36'd0);
        tick();
        check("rst_gnt1", 36'(ucb_gnt), 36'd0);
        check("rst_read", 36'(AT_read), 36'd0);
        check("rst_flip", 36'(flip_index), 36'd0);

        // Single request from buffer 4, then a competing one that must wait.
        rst     = 1'b1;
        ucb_req = 4'b1000;
        tick();
        check("gnt_1000", 36'(ucb_gnt), 36'h8);
        ucb_req = 4'b0100;
        run_clause(CL123, 5'd7, 12'h002);
        tick();
        check("gnt_0100", 36'(ucb_gnt), 36'h4);

        // Two requests: priority to 4, then 2 after release.
        ucb_req = 4'b1010;
        run_clause(CL123, 5'd30, 12'h001);
        tick();
        check("gnt_1000b", 36'(ucb_gnt), 36'h8);
        ucb_req = 4'b0010;
        run_clause(CL123, 5'd0, 12'h001);
        tick();
        check("gnt_0010", 36'(ucb_gnt), 36'h2);
        ucb_req = 4'b0000;

        // Reset in the middle of the read burst.
        tick();                 // LOAD
        reg_en = 1'b1;
        reg_in = {12'hABC, 12'h456, 12'h123};
        tick();                 // READ 0
        reg_en = 1'b0;
        tick();                 // READ 1
        rst = 1'b0;
        tick();
        check("midrst_gnt", 36'(ucb_gnt), 36'd0);
        check("midrst_read", 36'(AT_read), 36'd0);
        check("midrst_addr", 36'(AT_address), 36'd0);
        rst     = 1'b1;
        ucb_req = 4'b0001;
        tick();
        check("gnt_0001", 36'(ucb_gnt), 36'h1);
        ucb_req = 4'b0000;
        run_clause({12'h00F, 12'hF00, 12'h0F0}, 5'd2, 12'h00F);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) != 0);
            ucb_req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            reg_en  = ($urandom_range(0, 2) == 0);
            count   = 5'($urandom);
            reg_in  = {4'($urandom), 32'($urandom)};
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
